// File: rtl/clk_tick_sched_if.sv
// Configuration request/acknowledge port of the tick scheduler.
// The requester holds cfg_req until it sees the one-cycle cfg_ack.
interface clk_tick_sched_if #(
  parameter int PRE_W = 16
);
  logic             cfg_req;
  logic [2:0]       cfg_addr;
  logic [PRE_W-1:0] cfg_data;
  logic             cfg_ack;
  logic             cfg_err;

  modport master (output cfg_req, cfg_addr, cfg_data, input cfg_ack, cfg_err);
  modport slave  (input cfg_req, cfg_addr, cfg_data, output cfg_ack, cfg_err);
endinterface

// File: rtl/clk_tick_sched.sv
// Shared prescaler driving four programmable tick/square-clock channels.
// Compare writes are staged in shadows and applied together on a prescaler wrap.
module clk_tick_sched #(
  parameter int PRE_W   = 16,
  parameter int PRE_RST = 24414,
  parameter int CH_W    = 8,
  parameter int CH_RST  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      ch_en,
  clk_tick_sched_if.slave cfg,
  output logic            base_tick,
  output logic [3:0]      ch_tick,
  output logic [3:0]      ch_sclk
);
  typedef enum logic [1:0] {IDLE, PEND, ACK, WAIT} state_t;

  localparam logic [PRE_W-1:0] PRE_INIT = PRE_W'(PRE_RST);
  localparam logic [CH_W-1:0]  CH_INIT  = CH_W'(CH_RST);

  state_t                 state;
  logic                   err_flag;
  logic [PRE_W-1:0]       pre_cnt;
  logic [PRE_W-1:0]       pre_max;
  logic [PRE_W-1:0]       pre_shadow;
  logic [3:0][CH_W-1:0]   ch_cnt;
  logic [3:0][CH_W-1:0]   ch_max;
  logic [3:0][CH_W-1:0]   ch_shadow;
  logic                   wrap;
  logic                   apply;

  assign wrap  = (pre_cnt == pre_max);
  assign apply = wrap && (state == PEND);

  // Prescaler and channel dividers; ticks on the wrap are judged with the old compares.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt   <= '0;
      base_tick <= 1'b0;
      ch_cnt    <= '0;
      ch_tick   <= '0;
      ch_sclk   <= '0;
    end else begin
      base_tick <= wrap;
      pre_cnt   <= wrap ? '0 : pre_cnt + PRE_W'(1);
      for (int i = 0; i < 4; i++) begin
        ch_tick[i] <= 1'b0;
        if (!ch_en[i]) begin
          ch_cnt[i]  <= '0;
          ch_sclk[i] <= 1'b0;
        end else if (wrap) begin
          if (ch_cnt[i] == ch_max[i]) begin
            ch_cnt[i]  <= '0;
            ch_tick[i] <= 1'b1;
            ch_sclk[i] <= ~ch_sclk[i];
          end else begin
            ch_cnt[i] <= ch_cnt[i] + CH_W'(1);
          end
        end
        // Applying new compares realigns every channel phase.
        if (apply) ch_cnt[i] <= '0;
      end
    end
  end

  // Configuration handshake: one write per request, acknowledged after it takes effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      err_flag    <= 1'b0;
      cfg.cfg_ack <= 1'b0;
      cfg.cfg_err <= 1'b0;
      pre_max     <= PRE_INIT;
      pre_shadow  <= PRE_INIT;
      ch_max      <= {4{CH_INIT}};
      ch_shadow   <= {4{CH_INIT}};
    end else begin
      cfg.cfg_ack <= 1'b0;
      cfg.cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg.cfg_req) begin
            if (cfg.cfg_addr == 3'd4) begin
              pre_shadow <= cfg.cfg_data;
              err_flag   <= 1'b0;
              state      <= PEND;
            end else if (!cfg.cfg_addr[2]) begin
              ch_shadow[cfg.cfg_addr[1:0]] <= cfg.cfg_data[CH_W-1:0];
              err_flag <= 1'b0;
              state    <= PEND;
            end else begin
              err_flag <= 1'b1;
              state    <= ACK;
            end
          end
        end
        PEND: begin
          if (wrap) begin
            pre_max <= pre_shadow;
            ch_max  <= ch_shadow;
            state   <= ACK;
          end
        end
        ACK: begin
          cfg.cfg_ack <= 1'b1;
          cfg.cfg_err <= err_flag;
          state       <= WAIT;
        end
        WAIT: begin
          if (!cfg.cfg_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_clk_tick_sched.sv
// Scoreboard bench for clk_tick_sched: a timing model predicts every cycle's outputs,
// a monitor compares them one cycle at a time against the DUT.
module tb_clk_tick_sched;
  localparam int PRE_RST = 24414;

  localparam int M_FREE    = 0;
  localparam int M_PENDING = 1;
  localparam int M_ACKING  = 2;
  localparam int M_HELD    = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ch_en;
  logic       base_tick;
  logic [3:0] ch_tick;
  logic [3:0] ch_sclk;

  clk_tick_sched_if #(.PRE_W(16)) cfg_bus ();

  clk_tick_sched #(.PRE_W(16), .PRE_RST(PRE_RST), .CH_W(8), .CH_RST(0)) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .cfg(cfg_bus),
    .base_tick(base_tick), .ch_tick(ch_tick), .ch_sclk(ch_sclk)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       full;
    bit       base;
    bit [3:0] tick;
    bit [3:0] sclk;
    bit       ack;
    bit       err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference state: prescaler phase arithmetic and per-channel wrap counts.
  int unsigned m_pm, m_sh_pm, m_phase;
  int unsigned m_cm[4], m_sh_cm[4], m_ws[4];
  bit [3:0]    m_sclk;
  int          m_state, m_edge, m_ack_edge;
  bit          m_err, m_acked;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  function automatic void model_reset();
    m_pm = PRE_RST; m_sh_pm = PRE_RST; m_phase = 0;
    for (int i = 0; i < 4; i++) begin
      m_cm[i] = 0; m_sh_cm[i] = 0; m_ws[i] = 0;
    end
    m_sclk = '0; m_state = M_FREE; m_ack_edge = -1; m_err = 0; m_acked = 0;
  endfunction

  function automatic exp_t model_edge();
    exp_t x = '{default: 0};
    bit   wrap;
    bit   applied = 0;
    m_edge++;
    m_acked = 0;
    if (rst) begin
      model_reset();
      x.full = 1;
      return x;
    end
    wrap   = (m_phase % (m_pm + 1)) == m_pm;
    x.base = wrap;
    for (int i = 0; i < 4; i++) begin
      if (!ch_en[i]) begin
        m_ws[i] = 0; m_sclk[i] = 0;
      end else if (wrap) begin
        m_ws[i]++;
        if (m_ws[i] % (m_cm[i] + 1) == 0) begin
          x.tick[i] = 1; m_sclk[i] = ~m_sclk[i];
        end
      end
    end
    x.sclk = m_sclk;
    if (m_edge == m_ack_edge) begin
      x.ack = 1; x.err = m_err; m_acked = 1;
    end
    case (m_state)
      M_FREE: if (cfg_bus.cfg_req) begin
        if (cfg_bus.cfg_addr == 3'd4) begin
          m_sh_pm = cfg_bus.cfg_data; m_state = M_PENDING;
        end else if (cfg_bus.cfg_addr < 3'd4) begin
          m_sh_cm[cfg_bus.cfg_addr] = cfg_bus.cfg_data & 16'h00FF; m_state = M_PENDING;
        end else begin
          m_err = 1; m_ack_edge = m_edge + 1; m_state = M_ACKING;
        end
      end
      M_PENDING: if (wrap) begin
        m_pm = m_sh_pm;
        for (int i = 0; i < 4; i++) begin
          m_cm[i] = m_sh_cm[i]; m_ws[i] = 0;
        end
        applied = 1; m_err = 0; m_ack_edge = m_edge + 1; m_state = M_ACKING;
      end
      M_ACKING: if (m_edge == m_ack_edge) m_state = M_HELD;
      default:  if (!cfg_bus.cfg_req) m_state = M_FREE;
    endcase
    m_phase = applied ? 0 : m_phase + 1;
    return x;
  endfunction

  function automatic bit will_tick(input int i);
    return ((m_phase % (m_pm + 1)) == m_pm) && (((m_ws[i] + 1) % (m_cm[i] + 1)) == 0);
  endfunction

  // Edges until the next prescaler wrap that can apply a write sampled at the coming edge.
  function automatic int cycles_to_wrap();
    int unsigned c = m_phase % (m_pm + 1);
    return (c < m_pm) ? int'(m_pm - c) : int'(m_pm + 1);
  endfunction

  task automatic tick_cycle();
    sb_q.push_back(model_edge());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] d, input int hold, output int lat);
    int k = 0;
    lat = -1;
    cfg_bus.cfg_req = 1'b1; cfg_bus.cfg_addr = a; cfg_bus.cfg_data = d;
    do begin
      tick_cycle();
      k++;
      if (cfg_bus.cfg_ack && lat < 0) lat = k;
    end while (!m_acked && k < 70000);
    repeat (hold) tick_cycle();
    cfg_bus.cfg_req = 1'b0;
    tick_cycle();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 1) check("sb_depth", 32'(sb_q.size()), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.full || e.base || (|e.tick) || e.ack || base_tick || (|ch_tick) || cfg_bus.cfg_ack)
          check("outputs", 32'({base_tick, ch_tick, ch_sclk, cfg_bus.cfg_ack, cfg_bus.cfg_err}),
                32'({e.base, e.tick, e.sclk, e.ack, e.err}));
      end
    end
  end

  initial begin : driver
    int lat, exp_lat, cnt_base, cnt_t0, cnt_other, cnt_t2, k;
    logic [2:0] a;
    logic [15:0] d;
    m_edge = 0;
    model_reset();
    rst = 1'b1; ch_en = '0;
    cfg_bus.cfg_req = 1'b0; cfg_bus.cfg_addr = '0; cfg_bus.cfg_data = '0;
    #1;
    check("reset_outputs", 32'({base_tick, ch_tick, ch_sclk, cfg_bus.cfg_ack, cfg_bus.cfg_err}), 32'd0);
    repeat (3) tick_cycle();
    rst = 1'b0;

    cfg_write(3'd4, 16'd3, 0, lat);
    check("first_write_latency", 32'(lat), 32'(2 + PRE_RST));
    ch_en = 4'b0001;
    cnt_base = 0; cnt_t0 = 0; cnt_other = 0;
    repeat (40) begin
      tick_cycle();
      cnt_base += int'(base_tick); cnt_t0 += int'(ch_tick[0]);
      cnt_other += int'(|ch_tick[3:1]) + int'(|ch_sclk[3:1]);
    end
    check("base_rate_pm3", 32'(cnt_base), 32'd10);
    check("ch0_rate_cm0", 32'(cnt_t0), 32'd10);
    check("idle_channels_quiet", 32'(cnt_other), 32'd0);

    cfg_write(3'd2, 16'd4, 0, lat);
    ch_en = 4'b0101;
    cnt_t2 = 0;
    repeat (80) begin
      tick_cycle();
      cnt_t2 += int'(ch_tick[2]);
    end
    check("ch2_rate_20", 32'(cnt_t2), 32'd4);

    for (int n = 0; n < 8 && (m_phase % (m_pm + 1)) != 1; n++) tick_cycle();
    cfg_write(3'd4, 16'd9, 0, lat);
    check("write_latency_pm3", 32'(lat), 32'd4);
    repeat (30) tick_cycle();

    cfg_write(3'd6, 16'h0055, 5, lat);
    check("invalid_addr_latency", 32'(lat), 32'd2);
    repeat (25) tick_cycle();

    cfg_write(3'd1, 16'd1, 0, lat);
    ch_en = 4'b0111;
    for (int n = 0; n < 200 && !will_tick(1); n++) tick_cycle();
    ch_en[1] = 1'b0;
    tick_cycle();
    check("ch1_drop_no_tick", 32'(ch_tick[1]), 32'd0);
    check("ch1_drop_sclk", 32'(ch_sclk[1]), 32'd0);

    for (int n = 0; n < 60; n++) begin
      ch_en = 4'($urandom);
      repeat ($urandom_range(0, 20)) tick_cycle();
      a = 3'($urandom_range(0, 7));
      d = (a == 3'd4) ? 16'($urandom_range(0, 7)) : 16'($urandom_range(0, 5));
      exp_lat = (a > 3'd4) ? 2 : 2 + cycles_to_wrap();
      cfg_write(a, d, $urandom_range(0, 3), lat);
      check("rand_latency", 32'(lat), 32'(exp_lat));
    end

    cfg_write(3'd4, 16'd50, 0, lat);
    cfg_write(3'd0, 16'd0, 0, lat);
    ch_en = 4'b0001;
    for (int n = 0; n < 400 && !(m_sclk[0] && (m_phase % (m_pm + 1)) < 40); n++) tick_cycle();
    cfg_bus.cfg_req = 1'b1; cfg_bus.cfg_addr = 3'd4; cfg_bus.cfg_data = 16'd7;
    repeat (2) tick_cycle();
    check("pending_sclk_high", 32'(ch_sclk[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", 32'({base_tick, ch_tick, ch_sclk, cfg_bus.cfg_ack, cfg_bus.cfg_err}), 32'd0);
    cfg_bus.cfg_req = 1'b0;
    repeat (2) tick_cycle();
    rst = 1'b0;
    k = 0;
    do begin
      tick_cycle();
      k++;
    end while (!base_tick && k < 30000);
    check("first_base_after_reset", 32'(k), 32'(PRE_RST + 1));
    repeat (5) tick_cycle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/clk_tick_sched.md
# clk_tick_sched

Programmable tick scheduler that owns one shared prescaler and derives four independently configured tick strobes and slow square clocks from it. It sits between the system clock and the slow-rate consumers (display refresh, sampling, stepper/servo update) and replaces per-consumer free-running dividers. Divisors are changed at run time through a req/ack configuration port. Every change is applied atomically on a prescaler boundary, so no output ever produces a runt pulse.

## Interface
- PRE_W, 16, prescaler compare width
- PRE_RST, 24414, reset value of prescaler compare `pre_max`
- CH_W, 8, channel compare width
- CH_RST, 0, reset value of every channel compare `ch_max[i]`
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- ch_en  in  4  per-channel enable, level
- cfg_req  in  1  config request; held high until `cfg_ack`
- cfg_addr  in  3  0–3 = channel compare, 4 = prescaler compare, 5–7 = invalid
- cfg_data  in  PRE_W  write value; channel writes use bits [CH_W-1:0]
- cfg_ack  out  1  one-cycle completion pulse
- cfg_err  out  1  one-cycle pulse coincident with `cfg_ack` for an invalid address
- base_tick  out  1  one-cycle strobe every `pre_max`+1 cycles
- ch_tick  out  4  one-cycle strobe per channel
- ch_sclk  out  4  per-channel square clock, toggles on each `ch_tick`

## Operation
- Reset values: `pre_cnt`=0, `ch_cnt[i]`=0, `pre_max`=PRE_RST, `ch_max[i]`=CH_RST. All outputs are 0. The FSM is in IDLE and any pending write is discarded.
- Prescaler:
  - `wrap` = (`pre_cnt`==`pre_max`).
  - On `wrap`: `pre_cnt`<=0. Otherwise `pre_cnt` increments.
  - `base_tick`<=`wrap` (registered). When `pre_max`=0, `base_tick` stays high continuously.
- Channel i, enabled, in a `wrap` cycle:
  - If `ch_cnt[i]`==`ch_max[i]`: `ch_cnt[i]`<=0, `ch_tick[i]`<=1, `ch_sclk[i]`<=~`ch_sclk[i]`.
  - Otherwise `ch_cnt[i]` increments and `ch_tick[i]`<=0.
- Channel i, enabled, in a non-`wrap` cycle: `ch_tick[i]`<=0.
- Channel i disabled (`ch_en[i]`=0): `ch_cnt[i]`<=0, `ch_tick[i]`<=0, `ch_sclk[i]`<=0.
- Periods:
  - `ch_tick[i]` period = (`pre_max`+1)·(`ch_max[i]`+1) cycles.
  - `ch_sclk[i]` period = twice that, 50% duty.
- Config FSM states: IDLE, PEND, ACK, WAIT.
  - IDLE, `cfg_req`=1, valid addr: load data into the shadow register for that addr, go to PEND.
  - IDLE, `cfg_req`=1, invalid addr: go to ACK with the error flag set. No shadow change.
  - PEND, `wrap` cycle: copy every shadow into the active compares, set all `ch_cnt`<=0 (phase realign), go to ACK.
  - ACK: `cfg_ack`=1 (and `cfg_err` if flagged) for one cycle, go to WAIT.
  - WAIT: return to IDLE when `cfg_req`=0. Holding `cfg_req` high never causes a second write.
- Shadows track the active values at reset and after each apply. A write to one address leaves the other compares unchanged.
- Arithmetic: counters are unsigned, same width as their compare. Equality compare only, so counters never exceed `max`.

## Timing
- `base_tick` and `ch_tick` are registered. They assert in the cycle after the `wrap` edge and are mutually aligned: every `ch_tick` coincides with a `base_tick`.
- First `base_tick` after reset release: high during cycle `pre_max`+1, counting the first post-reset edge as edge 1.
- Apply-cycle rule: the `wrap` cycle that applies a write still evaluates ticks with the OLD `pre_max`/`ch_max`. The new prescaler period starts the next cycle.
- Write latency: from `cfg_req` sampled in IDLE, `cfg_ack` arrives 2 + (cycles to next `wrap`) cycles later. Worst case is `pre_max`+3.
- Invalid address: `cfg_ack` and `cfg_err` arrive 2 cycles after `cfg_req` is sampled.
- Enable edges:
  - Raising `ch_en[i]` mid-period starts counting at the next `wrap`.
  - Lowering it clears the channel on the next edge.
  - Lowering it in the same cycle as a would-be tick means the disable wins: no tick.
- `rst` asserted at any point, including PEND or ACK, forces reset values immediately. No `cfg_ack` is issued for the aborted write.

## Test plan
- Reset, `pre_max`=3 (via write), `ch_max`=0, `ch_en`=4'b0001 -> `base_tick` every 4 cycles; `ch_tick[0]` equals `base_tick`; `ch_sclk[0]` period 8 cycles; other channels stay 0.
- `pre_max`=3, `ch_max[2]`=4, `ch_en[2]`=1 -> `ch_tick[2]` every 20 cycles, always coincident with `base_tick`; `ch_sclk[2]` high for 20 cycles, low for 20.
- Write addr 4 = 9 while `pre_cnt`=1, old `pre_max`=3 -> `cfg_ack` 4 cycles after req; next `base_tick` gaps are 4 cycles and then 10; all `ch_cnt` restart at 0.
- Write addr 6 -> `cfg_ack` and `cfg_err` high together 2 cycles later; no compare changes; holding `cfg_req` high gives exactly one ack.
- Drop `ch_en[1]` in a cycle where `ch_cnt[1]`==`ch_max[1]` and `wrap`=1 -> no `ch_tick[1]`; `ch_sclk[1]`=0 next cycle.
- Assert `rst` while in PEND -> all outputs 0 at once, `pre_max`=24414, no `cfg_ack`; after release the first `base_tick` comes at cycle 24415.
